// File: rtl/vga_if.sv
// Pixel-scan interface: raster position, sync levels and frame event pulses.
// The timing generator drives the master side; the graphics wrapper reads
// the slave side. There is no handshake: every field is a registered level
// or a one-cycle pulse, valid in each cycle of the pixel clock.
interface vga_if #(
  parameter int W = 10
);
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         hsync;
  logic         vsync;
  logic         video_on;
  logic         line_start;
  logic         frame_start;
  logic         vblank_start;
  logic [7:0]   frame_count;

  modport master (
    output X, Y, hsync, vsync, video_on,
    output line_start, frame_start, vblank_start, frame_count
  );

  modport slave (
    input X, Y, hsync, vsync, video_on,
    input line_start, frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Raster timing generator, 640x480@60 by default (800 x 525 clocks/frame).
// Every output is decoded from the next X/Y value and registered, so all
// flags and pulses line up with the X/Y shown in the same cycle.
module vga_timing_generator #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int H_VISIBLE         = 640,
  parameter int H_FRONT           = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int V_VISIBLE         = 480,
  parameter int V_FRONT           = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33,
  parameter bit SYNC_ACTIVE       = 1'b0
) (
  input  logic clock_25,
  input  logic reset,
  vga_if.master vga
);

  localparam int W       = PIXEL_DISPLAY_BIT + 1;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [W-1:0] H_LAST   = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_LAST   = W'(V_TOTAL - 1);
  localparam logic [W-1:0] H_VIS    = W'(H_VISIBLE);
  localparam logic [W-1:0] V_VIS    = W'(V_VISIBLE);
  localparam logic [W-1:0] HS_START = W'(H_VISIBLE + H_FRONT);
  localparam logic [W-1:0] HS_END   = W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [W-1:0] VS_START = W'(V_VISIBLE + V_FRONT);
  localparam logic [W-1:0] VS_END   = W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [W-1:0] x_q, y_q;
  logic [W-1:0] x_next, y_next;
  logic         x_wrap, y_wrap;
  logic         hsync_q, vsync_q, video_on_q;
  logic         line_start_q, frame_start_q, vblank_start_q;
  logic [7:0]   frame_count_q;

  // Next raster position; >= makes any out-of-range value fall back to 0.
  always_comb begin
    x_wrap = (x_q >= H_LAST);
    y_wrap = (y_q >= V_LAST);
    x_next = x_wrap ? '0 : x_q + 1'b1;
    y_next = y_q;
    if (x_wrap) begin
      y_next = y_wrap ? '0 : y_q + 1'b1;
    end
  end

  // Counters and every port-facing flag, registered from the next position.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      hsync_q        <= ~SYNC_ACTIVE;
      vsync_q        <= ~SYNC_ACTIVE;
      video_on_q     <= 1'b1;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      x_q            <= x_next;
      y_q            <= y_next;
      hsync_q        <= (x_next >= HS_START && x_next < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q        <= (y_next >= VS_START && y_next < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_q     <= (x_next < H_VIS) && (y_next < V_VIS);
      line_start_q   <= x_wrap;
      frame_start_q  <= x_wrap && y_wrap;
      vblank_start_q <= x_wrap && (y_next == V_VIS);
      if (x_wrap && y_wrap) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign vga.X            = x_q;
  assign vga.Y            = y_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.video_on     = video_on_q;
  assign vga.line_start   = line_start_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;
  assign vga.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator. Instance A uses full 640x480 timing for the
// horizontal checks; instance B uses a tiny raster (16 x 12 clocks, hsync at
// X 10..12, vsync at Y 7..8, vblank at Y 6) so frame-level behaviour,
// including 256-frame wrap, fits in a short run.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc_a, cyc_b;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Clock / reset block
  always #20 clk = ~clk;

  vga_if #(.W(10)) bus_a ();
  vga_if #(.W(5))  bus_b ();

  vga_timing_generator dut_a (
    .clock_25 (clk),
    .reset    (rst_a),
    .vga      (bus_a.master)
  );

  vga_timing_generator #(
    .PIXEL_DISPLAY_BIT (4),
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
    .SYNC_ACTIVE (1'b0)
  ) dut_b (
    .clock_25 (clk),
    .reset    (rst_b),
    .vga      (bus_b.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cyc_a=%0d cyc_b=%0d)", tag, got, exp, cyc_a, cyc_b);
    end
  endtask

  // One clock; outputs are then sampled at the following negedge.
  task automatic step();
    @(negedge clk);
    cyc_a++;
    cyc_b++;
  endtask

  task automatic goto_a(input int t);
    while (cyc_a < t) step();
  endtask

  task automatic goto_b(input int t);
    while (cyc_b < t) step();
  endtask

  task automatic check_a(input string tag, input int x, input int y, input bit hs,
                         input bit vs, input bit von, input bit ls, input bit fs,
                         input bit vb, input int fc);
    check({tag, ".X"},  32'(bus_a.X), 32'(x));
    check({tag, ".Y"},  32'(bus_a.Y), 32'(y));
    check({tag, ".hs"}, 32'(bus_a.hsync), 32'(hs));
    check({tag, ".vs"}, 32'(bus_a.vsync), 32'(vs));
    check({tag, ".von"}, 32'(bus_a.video_on), 32'(von));
    check({tag, ".ls"}, 32'(bus_a.line_start), 32'(ls));
    check({tag, ".fs"}, 32'(bus_a.frame_start), 32'(fs));
    check({tag, ".vb"}, 32'(bus_a.vblank_start), 32'(vb));
    check({tag, ".fc"}, 32'(bus_a.frame_count), 32'(fc));
  endtask

  task automatic check_b(input string tag, input int x, input int y, input bit hs,
                         input bit vs, input bit von, input bit ls, input bit fs,
                         input bit vb, input int fc);
    check({tag, ".X"},  32'(bus_b.X), 32'(x));
    check({tag, ".Y"},  32'(bus_b.Y), 32'(y));
    check({tag, ".hs"}, 32'(bus_b.hsync), 32'(hs));
    check({tag, ".vs"}, 32'(bus_b.vsync), 32'(vs));
    check({tag, ".von"}, 32'(bus_b.video_on), 32'(von));
    check({tag, ".ls"}, 32'(bus_b.line_start), 32'(ls));
    check({tag, ".fs"}, 32'(bus_b.frame_start), 32'(fs));
    check({tag, ".vb"}, 32'(bus_b.vblank_start), 32'(vb));
    check({tag, ".fc"}, 32'(bus_b.frame_count), 32'(fc));
  endtask

  initial begin
    cyc_a = 0;
    cyc_b = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    cyc_a = 0;

    // ---------------- Instance A: full-size horizontal timing -----------
    //        tag        X    Y  hs vs von ls fs vb fc
    check_a("a_reset",   0,   0, 1, 1, 1,  0, 0, 0, 0);
    goto_a(1);   check_a("a_c1",    1,   0, 1, 1, 1, 0, 0, 0, 0);
    goto_a(639); check_a("a_c639",  639, 0, 1, 1, 1, 0, 0, 0, 0);
    goto_a(640); check_a("a_c640",  640, 0, 1, 1, 0, 0, 0, 0, 0);
    goto_a(655); check_a("a_c655",  655, 0, 1, 1, 0, 0, 0, 0, 0);
    goto_a(656); check_a("a_c656",  656, 0, 0, 1, 0, 0, 0, 0, 0);
    goto_a(751); check_a("a_c751",  751, 0, 0, 1, 0, 0, 0, 0, 0);
    goto_a(752); check_a("a_c752",  752, 0, 1, 1, 0, 0, 0, 0, 0);
    goto_a(799); check_a("a_c799",  799, 0, 1, 1, 0, 0, 0, 0, 0);
    goto_a(800); check_a("a_c800",  0,   1, 1, 1, 1, 1, 0, 0, 0);
    goto_a(801); check_a("a_c801",  1,   1, 1, 1, 1, 0, 0, 0, 0);
    goto_a(1600); check_a("a_c1600", 0,  2, 1, 1, 1, 1, 0, 0, 0);
    goto_a(1700); check_a("a_c1700", 100, 2, 1, 1, 1, 0, 0, 0, 0);
    // Mid-line reset for one clock returns to (0,0) with pulses clear.
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cyc_a = 0;
    check_a("a_rst_mid", 0, 0, 1, 1, 1, 0, 0, 0, 0);
    goto_a(1);   check_a("a_rst_c1", 1, 0, 1, 1, 1, 0, 0, 0, 0);
    goto_a(800); check_a("a_rst_c800", 0, 1, 1, 1, 1, 1, 0, 0, 0);

    // ---------------- Instance B: tiny raster, frame behaviour ----------
    rst_b = 1'b0;
    cyc_b = 0;
    //        tag        X   Y  hs vs von ls fs vb fc
    check_b("b_reset",   0,  0, 1, 1, 1, 0, 0, 0, 0);
    goto_b(9);   check_b("b_c9",   9,  0, 1, 1, 0, 0, 0, 0, 0);
    goto_b(10);  check_b("b_c10",  10, 0, 0, 1, 0, 0, 0, 0, 0);
    goto_b(12);  check_b("b_c12",  12, 0, 0, 1, 0, 0, 0, 0, 0);
    goto_b(13);  check_b("b_c13",  13, 0, 1, 1, 0, 0, 0, 0, 0);
    goto_b(96);  check_b("b_vbl",  0,  6, 1, 1, 0, 1, 0, 1, 0);
    goto_b(97);  check_b("b_vbl1", 1,  6, 1, 1, 0, 0, 0, 0, 0);
    goto_b(111); check_b("b_y6e",  15, 6, 1, 1, 0, 0, 0, 0, 0);
    goto_b(112); check_b("b_y7",   0,  7, 1, 0, 0, 1, 0, 0, 0);
    goto_b(143); check_b("b_y8e",  15, 8, 1, 0, 0, 0, 0, 0, 0);
    goto_b(144); check_b("b_y9",   0,  9, 1, 1, 0, 1, 0, 0, 0);
    goto_b(191); check_b("b_last", 15, 11, 1, 1, 0, 0, 0, 0, 0);
    goto_b(192); check_b("b_frm1", 0,  0, 1, 1, 1, 1, 1, 0, 1);
    goto_b(193); check_b("b_frm1n", 1, 0, 1, 1, 1, 0, 0, 0, 1);
    goto_b(288); check_b("b_vbl2", 0,  6, 1, 1, 0, 1, 0, 1, 1);
    // (11,7) in frame 1: both syncs active when reset hits.
    goto_b(315); check_b("b_pre_rst", 11, 7, 0, 0, 0, 0, 0, 0, 1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    cyc_b = 0;
    check_b("b_rst_mid", 0, 0, 1, 1, 1, 0, 0, 0, 0);
    goto_b(1);   check_b("b_rst_c1", 1, 0, 1, 1, 1, 0, 0, 0, 0);
    goto_b(192); check_b("b_rfrm1", 0, 0, 1, 1, 1, 1, 1, 0, 1);
    goto_b(384); check_b("b_rfrm2", 0, 0, 1, 1, 1, 1, 1, 0, 2);
    goto_b(255 * 192 + 191);
    check_b("b_f255e", 15, 11, 1, 1, 0, 0, 0, 0, 255);
    goto_b(256 * 192);
    check_b("b_f256", 0, 0, 1, 1, 1, 1, 1, 0, 0);
    goto_b(256 * 192 + 1);
    check_b("b_f256n", 1, 0, 1, 1, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
